// File: rtl/evt_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : evt_arb_pkg
// Brief   : Shared state types and the round-robin pick helper for evt_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
package evt_arb_pkg;

    localparam int MAX_N = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EDGE     = 2'd1,
        WAIT_LOW = 2'd2
    } edge_state_t;

    typedef enum logic {
        A_IDLE  = 1'b0,
        A_OFFER = 1'b1
    } arb_state_t;

    // Unused request bits above N are zero, so wrapping mod MAX_N visits the
    // live channels in the same order as wrapping mod N.
    function automatic logic [3:0] rr_pick(input logic [MAX_N-1:0] req,
                                           input logic [3:0]       ptr);
        logic [3:0] grant;
        logic       found;
        int         idx;
        grant = ptr;
        found = 1'b0;
        for (int k = 0; k < MAX_N; k++) begin
            idx = (int'(ptr) + k) % MAX_N;
            if (!found && req[idx]) begin
                grant = 4'(idx);
                found = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage
`default_nettype wire

// File: rtl/evt_arbiter_edge.sv
`default_nettype none
// ============================================================================
// Module  : evt_edge
// Brief   : Per-channel rising-edge FSM; one tick per high phase of sig.
// Revision: 1.0 - initial release
// ============================================================================
module evt_edge
    import evt_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic sig,
    output logic tick
);

    edge_state_t state;
    edge_state_t state_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick      = 1'b0;
        case (state)
            IDLE:     if (sig) state_nxt = EDGE;
            EDGE: begin
                tick      = 1'b1;
                state_nxt = WAIT_LOW;
            end
            WAIT_LOW: if (!sig) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/evt_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : evt_arbiter
// Brief   : Serialises per-channel rising-edge events onto one valid/ready
//           port with round-robin arbitration. EVT_ARB_DROP_CNT_EN adds a
//           saturating drop counter port (drop_cnt).
// Revision: 1.0 - initial release
// ============================================================================
module evt_arbiter
    import evt_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         sig,
    output logic                 evt_valid,
    output logic [$clog2(N)-1:0] evt_id,
    input  logic                 evt_ready,
    output logic [N-1:0]         pending
`ifdef EVT_ARB_DROP_CNT_EN
    ,
    output logic [DW-1:0]        drop_cnt
`endif
);

    localparam int IW = $clog2(N);

    if (N < 2 || N > MAX_N || DW < 1) begin : g_bad_param
        $error("evt_arbiter: N must be 2..16 and DW at least 1");
    end

    arb_state_t       state;
    arb_state_t       state_nxt;
    logic [IW-1:0]    id_nxt;
    logic [IW-1:0]    ptr_nxt;
    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    id_inc;
    logic [N-1:0]     tick;
    logic [N-1:0]     clr;
    logic [MAX_N-1:0] req_all;
    logic [MAX_N-1:0] req_rest;
    logic             hs;

    for (genvar i = 0; i < N; i++) begin : g_edge
        evt_edge u_edge (
            .clk  (clk),
            .rst  (rst),
            .sig  (sig[i]),
            .tick (tick[i])
        );
    end

    assign evt_valid = (state == A_OFFER);
    assign hs        = evt_valid & evt_ready;
    assign id_inc    = (evt_id == IW'(N - 1)) ? '0 : evt_id + IW'(1);
    assign clr       = hs ? (N'(1) << evt_id) : '0;

    // A same-cycle tick wins over the clear, so a fresh event is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~clr) | tick;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= A_IDLE;
            evt_id <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_nxt;
            evt_id <= id_nxt;
            rr_ptr <= ptr_nxt;
        end
    end

    // Re-arbitration sees only the registered flags, never this cycle's ticks.
    always_comb begin
        state_nxt = state;
        id_nxt    = evt_id;
        ptr_nxt   = rr_ptr;
        req_all   = MAX_N'(pending);
        req_rest  = req_all & ~MAX_N'(clr);
        case (state)
            A_IDLE: begin
                if (|pending) begin
                    state_nxt = A_OFFER;
                    id_nxt    = IW'(rr_pick(req_all, 4'(rr_ptr)));
                end
            end
            A_OFFER: begin
                if (hs) begin
                    ptr_nxt = id_inc;
                    if (|req_rest) begin
                        id_nxt = IW'(rr_pick(req_rest, 4'(id_inc)));
                    end else begin
                        state_nxt = A_IDLE;
                    end
                end
            end
            default: state_nxt = A_IDLE;
        endcase
    end

`ifdef EVT_ARB_DROP_CNT_EN
    logic [N-1:0]  drop;
    logic [DW+4:0] drop_sum;

    assign drop = tick & pending & ~clr;

    always_comb begin
        drop_sum = (DW + 5)'(drop_cnt);
        for (int i = 0; i < N; i++) begin
            drop_sum = drop_sum + (DW + 5)'(drop[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (drop_sum > (DW + 5)'({DW{1'b1}})) begin
            drop_cnt <= '1;
        end else begin
            drop_cnt <= drop_sum[DW-1:0];
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_evt_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_evt_arbiter
// Brief   : Self-checking bench for evt_arbiter (directed + random traffic).
// Revision: 1.0 - initial release
// ============================================================================
module tb_evt_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         evt_ready;
    logic [N-1:0] sig;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic [N-1:0] pending;
`ifdef EVT_ARB_DROP_CNT_EN
    logic [7:0]   drop_cnt;
    logic         evt_valid2;
    logic [1:0]   evt_id2;
    logic [N-1:0] pending2;
    logic [1:0]   drop_cnt2;
`endif

    always #5 clk = ~clk;

    evt_arbiter #(.N(N), .DW(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .sig       (sig),
        .evt_valid (evt_valid),
        .evt_id    (evt_id),
        .evt_ready (evt_ready),
        .pending   (pending)
`ifdef EVT_ARB_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

`ifdef EVT_ARB_DROP_CNT_EN
    evt_arbiter #(.N(N), .DW(2)) dut_sat (
        .clk       (clk),
        .rst       (rst),
        .sig       (sig),
        .evt_valid (evt_valid2),
        .evt_id    (evt_id2),
        .evt_ready (evt_ready),
        .pending   (pending2),
        .drop_cnt  (drop_cnt2)
    );
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: events, pending set and the offer, at transaction level.
    logic [N-1:0] m_pend;
    logic [N-1:0] m_tick;
    bit           armed   [N];
    int           ev_edge [N];
    bit           m_valid;
    int           m_id;
    int           m_ptr;
    int           m_drop;
    int           edge_n = 0;
    int           tb_cyc = 0;
    int           hs_ids [$];
    int           hs_cyc [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int search(input logic [N-1:0] req, input int from);
        for (int k = 0; k < N; k++) begin
            if (req[(from + k) % N]) return (from + k) % N;
        end
        return from;
    endfunction

    function automatic int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_tick  = '0;
        m_valid = 1'b0;
        m_id    = 0;
        m_ptr   = 0;
        m_drop  = 0;
        for (int i = 0; i < N; i++) begin
            armed[i]   = 1'b1;
            ev_edge[i] = -10;
        end
    endtask

    task automatic model_edge();
        bit           hs;
        bit           clr;
        logic [N-1:0] np;
        logic [N-1:0] newt;
        logic [N-1:0] rest;
        hs   = m_valid && evt_ready;
        newt = '0;
        np   = '0;
        for (int i = 0; i < N; i++) begin
            if (armed[i] && sig[i]) begin
                newt[i]    = 1'b1;
                armed[i]   = 1'b0;
                ev_edge[i] = edge_n;
            end else if (!armed[i] && edge_n >= ev_edge[i] + 2 && !sig[i]) begin
                armed[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            clr = hs && (m_id == i);
            if (m_tick[i]) begin
                if (m_pend[i] && !clr) m_drop++;
                np[i] = 1'b1;
            end else begin
                np[i] = m_pend[i] && !clr;
            end
        end
        if (!m_valid) begin
            if (m_pend != '0) begin
                m_valid = 1'b1;
                m_id    = search(m_pend, m_ptr);
            end
        end else if (hs) begin
            m_ptr      = (m_id + 1) % N;
            rest       = m_pend;
            rest[m_id] = 1'b0;
            if (rest != '0) m_id = search(rest, m_ptr);
            else            m_valid = 1'b0;
        end
        m_pend = np;
        m_tick = newt;
        edge_n++;
    endtask

    task automatic compare_all();
        chk("evt_valid", evt_valid, m_valid);
        if (m_valid) chk("evt_id", evt_id, m_id);
        chk("pending", pending, m_pend);
`ifdef EVT_ARB_DROP_CNT_EN
        chk("drop_cnt", drop_cnt, sat(m_drop, 255));
        chk("sat_valid", evt_valid2, m_valid);
        chk("sat_pending", pending2, m_pend);
        chk("sat_drop_cnt", drop_cnt2, sat(m_drop, 3));
`endif
    endtask

    task automatic cyc();
        if (evt_valid && evt_ready) begin
            hs_ids.push_back(int'(evt_id));
            hs_cyc.push_back(tb_cyc);
        end
        @(posedge clk);
        tb_cyc++;
        if (!rst) model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_valid", evt_valid, 0);
        chk("rst_id", evt_id, 0);
        chk("rst_pending", pending, 0);
        cyc();
        cyc();
        rst = 1'b0;
        hs_ids.delete();
        hs_cyc.delete();
    endtask

    initial begin
        rst       = 1'b1;
        sig       = '0;
        evt_ready = 1'b0;
        model_reset();
        #2;
        do_reset();

        // 1: single pulse on channel 2, latency and one handshake
        evt_ready = 1'b1;
        sig[2]    = 1'b1;
        cyc();
        chk("t1_no_valid_t", evt_valid, 0);
        cyc();
        chk("t1_pend_t1", pending[2], 1);
        chk("t1_no_valid_t1", evt_valid, 0);
        cyc();
        chk("t1_valid_t2", evt_valid, 1);
        chk("t1_id_t2", evt_id, 2);
        repeat (2) cyc();
        sig = '0;
        repeat (6) cyc();
        chk("t1_hs_count", hs_ids.size(), 1);
        chk("t1_pending_clear", pending, 0);

        // 2: all four channels at once, back-to-back grants
        do_reset();
        evt_ready = 1'b1;
        sig       = 4'hF;
        repeat (10) cyc();
        sig = '0;
        repeat (3) cyc();
        chk("t2_hs_count", hs_ids.size(), 4);
        for (int k = 0; k < 4 && k < hs_ids.size(); k++) begin
            chk("t2_id_order", hs_ids[k], k);
            chk("t2_no_bubble", hs_cyc[k] - hs_cyc[0], k);
        end
        chk("t2_valid_falls", evt_valid, 0);

        // 3: stalled offer on channel 1
        do_reset();
        evt_ready = 1'b0;
        sig       = 4'b0010;
        repeat (3) cyc();
        sig = '0;
        for (int k = 0; k < 10; k++) begin
            cyc();
            chk("t3_hold_valid", evt_valid, 1);
            chk("t3_hold_id", evt_id, 1);
        end
        evt_ready = 1'b1;
        cyc();
        chk("t3_hs_count", hs_ids.size(), 1);
        chk("t3_valid_after", evt_valid, 0);

        // 4: round-robin wrap after granting channel 3
        do_reset();
        evt_ready = 1'b1;
        sig       = 4'b1000;
        repeat (3) cyc();
        sig = '0;
        repeat (6) cyc();
        evt_ready = 1'b0;
        hs_ids.delete();
        sig = 4'b1001;
        repeat (4) cyc();
        sig       = '0;
        evt_ready = 1'b1;
        repeat (4) cyc();
        chk("t4_hs_count", hs_ids.size(), 2);
        if (hs_ids.size() == 2) begin
            chk("t4_first", hs_ids[0], 0);
            chk("t4_second", hs_ids[1], 3);
        end

        // 5: two edges while stalled; one event delivered, one dropped
        do_reset();
        evt_ready = 1'b0;
        sig = 4'b0010; repeat (3) cyc();
        sig = '0;      repeat (3) cyc();
        sig = 4'b0010; repeat (3) cyc();
        sig = '0;      repeat (2) cyc();
        chk("t5_pending1", pending[1], 1);
`ifdef EVT_ARB_DROP_CNT_EN
        chk("t5_drop_one", drop_cnt, 1);
`endif
        evt_ready = 1'b1;
        repeat (4) cyc();
        chk("t5_hs_count", hs_ids.size(), 1);
        evt_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            sig = 4'b0010; repeat (2) cyc();
            sig = '0;      repeat (3) cyc();
        end
`ifdef EVT_ARB_DROP_CNT_EN
        chk("t5_drop_six", drop_cnt, 6);
        chk("t5_drop_sat", drop_cnt2, 3);
`endif
        evt_ready = 1'b1;
        repeat (4) cyc();

        // 6: reset mid-offer with channel 0 held high
        do_reset();
        evt_ready = 1'b0;
        sig       = 4'b0001;
        repeat (3) cyc();
        chk("t6_offered", evt_valid, 1);
        do_reset();
        evt_ready = 1'b1;
        repeat (6) cyc();
        chk("t6_hs_count", hs_ids.size(), 1);
        if (hs_ids.size() == 1) chk("t6_id", hs_ids[0], 0);
        sig = '0;

        // random traffic against the model
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) sig[i] = ~sig[i];
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        sig       = '0;
        evt_ready = 1'b1;
        repeat (10) cyc();
        chk("rand_drained", evt_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/evt_arbiter.md
# evt_arbiter

Collects rising-edge events from N asynchronous-to-logic, clock-synchronous level inputs (buttons, status lines) and serialises them onto one shared event port with a valid/ready handshake. Each channel has its own edge FSM and a one-deep pending flag. A round-robin arbiter chooses which pending channel is offered to the single downstream consumer, typically a command decoder or a counter bank.

## Interface
- `N`, default 4: number of input channels, 2..16.
- `DW`, default 8: width of the drop counter, used only with the macro.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sig` in N: level inputs, already synchronised to `clk`.
- `evt_valid` out 1: an event is offered.
- `evt_id` out $clog2(N): channel index of the offered event.
- `evt_ready` in 1: the consumer accepts; handshake = `evt_valid & evt_ready` at a rising edge.
- `pending` out N: per-channel pending flags, registered.
- `drop_cnt` out DW: number of dropped events; present only with `EVT_ARB_DROP_CNT_EN`.

## Operation
- **Per-channel edge FSM (`evt_edge`)**
  - States and transitions:
    - IDLE → EDGE when `sig[i]` = 1.
    - EDGE → WAIT_LOW unconditionally.
    - WAIT_LOW → IDLE when `sig[i]` = 0.
  - `tick[i]` = 1 only in EDGE, so one event is produced per high phase.
  - A level already high when reset releases counts as an edge.
- **Pending flags**
  - `pending[i]` is set on `tick[i]`.
  - It is cleared on a handshake with `evt_id` = i.
  - Tick and clear in the same cycle for the same channel: the flag stays 1. This is a new event, not a drop.
  - Tick while the flag is already 1 with no clear that cycle: the event is dropped.
- **Arbiter FSM**
  - States and transitions:
    - A_IDLE → A_OFFER when `pending` ≠ 0. The grant is registered into `evt_id`.
    - A_OFFER with handshake: clear the granted flag, then either
      - grant the next channel when (`pending` & ~granted bit) ≠ 0, staying in A_OFFER, or
      - go to A_IDLE otherwise.
    - A_OFFER without handshake: hold.
  - `evt_valid` = (state == A_OFFER).
  - Round-robin search starts at `rr_ptr` and rises with wrap mod N.
  - `rr_ptr` is set to grant+1 mod N on each handshake, so it wraps from N-1 to 0.
  - A tick in the handshake cycle is not visible to that cycle's re-arbitration. It is seen from the next cycle on.
- **Offer stability**: while `evt_valid` = 1 and `evt_ready` = 0, `evt_id` is stable and `evt_valid` does not drop.
- **Reset values**: `evt_valid` = 0, `evt_id` = 0, `pending` = 0, `drop_cnt` = 0, `rr_ptr` = 0. All edge FSMs go to IDLE and the arbiter to A_IDLE.
- **Reset mid-offer**: the offered event and all pending events are discarded.

## Timing
- `sig[i]` first sampled high at edge t:
  - `tick[i]` is high during cycle t..t+1.
  - `pending[i]` = 1 after edge t+1.
  - `evt_valid` = 1 after edge t+2.
  - Minimum latency is 2 cycles.
- Back-to-back grants with no bubble when another channel is pending at the handshake.
- A single channel re-arms after `sig` spends at least one sampled cycle low (WAIT_LOW → IDLE).

## Configuration
- Macro: `EVT_ARB_DROP_CNT_EN`.
- **With the macro defined**
  - The `drop_cnt` port and its register exist.
  - The register increments by 1 per dropped event and saturates at 2^DW-1.
  - Simultaneous drops on k channels add k, then saturate.
- **Without the macro**: the port and its logic are absent and drops are silent. All other behaviour is identical.

## Structure
- Package `evt_arb_pkg` holds:
  - `edge_state_t` {IDLE, EDGE, WAIT_LOW}.
  - `arb_state_t` {A_IDLE, A_OFFER}.
  - The function `rr_pick(req, ptr)`, which returns the granted index.
- Sub-module `evt_edge`: one instance per channel via `generate`, with ports `clk`, `rst`, `sig`, `tick`.
- Top level holds the pending flags, the arbiter FSM, `rr_ptr` and `drop_cnt`.

## Test plan
1. Reset, `evt_ready` = 1, pulse `sig[2]` high for 5 cycles.
   - `evt_valid` rises 2 cycles after the first sampled high, with `evt_id` = 2.
   - Exactly one handshake; `pending` returns to 0.
2. Raise `sig[0..3]` in the same cycle with `evt_ready` = 1.
   - Four consecutive handshakes with ids 0,1,2,3 and no bubble.
   - `evt_valid` then falls.
3. Hold `evt_ready` = 0 with channel 1 offered, for 10 cycles.
   - `evt_id` stays 1 and `evt_valid` stays high.
   - Raise `evt_ready`: handshake in that cycle.
4. Round-robin wrap: grant 3, then pend channels 0 and 3 together.
   - Next grant is 0, then 3.
5. With `evt_ready` = 0, toggle `sig[1]` high/low/high (two edges).
   - `pending[1]` = 1 and `drop_cnt` = 1 (macro on).
   - One event is delivered.
   - With `DW` = 2 and 5 drops, `drop_cnt` saturates at 3.
6. Assert `rst` while `evt_valid` = 1 and `sig[0]` is high.
   - All outputs return to their reset values.
   - After release, channel 0 produces one event, because the held-high level counts as an edge.
